ram8_ctrl: RTL and testbench
============================

Name: ram8_ctrl

Overview:
- Request-driven controller and storage for a small word-addressed memory of DEPTH = 2**ADDR_W words, each WIDTH bits wide, with 8 words by default.
- It sits directly upstream of the load-enabled bit cells. It decodes write requests into per-word load strobes plus shared write data, and it returns read data through a valid/ready response port.
- It is the stage that produces the `in`/`load` pairs the storage cells consume.

Parameters:
- WIDTH, 16, bits per word.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the controller accepts the request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target word address.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  read data is valid.
- rsp_ready  in  1  the consumer takes the read data.
- rsp_rdata  out  WIDTH  read data; held stable while rsp_valid=1 and rsp_ready=0.
- word_load  out  DEPTH  one-hot per-word load strobe, combinational; all zero when no write is accepted.
- busy  out  1  high in any state other than IDLE.
- clear_req  in  1  clear command; present only with RAM8_CLEAR_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on reset_n.
- Reset (reset_n=0 at a clk edge):
  - state goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - Storage words are NOT reset; their contents are retained or undefined.
- Handshake: a request is accepted when req_valid & req_ready. A response is consumed when rsp_valid & rsp_ready.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). It is never asserted in CLEAR.
- req_valid, req_write, req_addr and req_wdata must stay stable until the request is accepted. The controller does not register a request before it accepts it.
- Write accept:
  - word_load[req_addr]=1 in the same cycle.
  - mem[req_addr] <= req_wdata on that edge.
  - Next state: IDLE.
- Read accept:
  - rsp_rdata <= mem[req_addr] on the accepting edge; rsp_valid=1 in the next cycle.
  - Next state: RESP. Latency is 1 cycle.
- States:
  - IDLE: accepts requests. With the macro, a clear_req moves to CLEAR.
  - RESP: holds rsp_valid=1. If rsp_ready=0, stay in RESP and hold rsp_rdata. If rsp_ready=1 and no request is accepted, go to IDLE with rsp_valid=0.
  - RESP with rsp_ready=1 and a read accepted the same cycle: rsp_valid stays 1 and rsp_rdata updates, giving one read per cycle back-to-back.
  - RESP with rsp_ready=1 and a write accepted: go to IDLE with rsp_valid=0.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data. There is no same-cycle hazard, because only one request is accepted per cycle.
- Addresses are always in range (ADDR_W bits cover DEPTH exactly); there is no wrap logic.
- Reset mid-operation:
  - A pending response is dropped (rsp_valid=0).
  - A write accepted on the same edge as reset is still committed: storage ignores reset_n.
  - A CLEAR sequence in progress is aborted; words not yet cleared keep their old data.

Optional Feature:
- Macro: RAM8_CLEAR_EN.
- With the macro defined:
  - The clear_req port exists.
  - clear_req=1 in IDLE moves to CLEAR on the next edge, with req_ready=0.
  - CLEAR writes 0 to words 0,1,...,DEPTH-1, one per cycle, in ascending order, asserting word_load accordingly. It takes DEPTH cycles, then returns to IDLE.
  - busy=1 throughout CLEAR.
  - If clear_req and req_valid are both high in IDLE, clear wins and the request is not accepted.
  - clear_req in RESP is ignored until IDLE.
- Without the macro: no clear_req port, no CLEAR state, and busy is high only in RESP.

Test Plan:
1. Reset, then write addr 3 = 0xBEEF: word_load=8'b0000_1000 for 1 cycle. A read of addr 3 gives rsp_valid the next cycle with rsp_rdata=0xBEEF.
2. Back-to-back reads of addr 0..7 (preloaded 0x1000+i) with rsp_ready=1: req_ready stays 1. rsp_rdata = 0x1000..0x1007 on consecutive cycles, with no bubbles.
3. Backpressure: read addr 5 with rsp_ready=0 for 4 cycles. rsp_valid=1 and rsp_rdata stay constant, req_ready=0, and a second req_valid is not accepted.
4. Write addr 2 = 0x00FF, then read addr 2 the next cycle: returns 0x00FF.
5. Reset asserted while in RESP: the next cycle shows rsp_valid=0, rsp_rdata=0, busy=0. Previously written storage still reads back its old value.
6. RAM8_CLEAR_EN: fill all words with 0xFFFF, assert clear_req together with a req_valid write. The write is not accepted. word_load walks 0x01..0x80 over 8 cycles with busy=1, and all reads then return 0.

Source files
------------

// File: rtl/ram8_ctrl.sv
// Request-driven controller and storage for a small word-addressed memory.
// Optional build macro RAM8_CLEAR_EN adds clear_req and a sequential CLEAR walk.
module ram8_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic [2**ADDR_W-1:0]  word_load,
  output logic                  busy
`ifdef RAM8_CLEAR_EN
  ,
  input  logic                  clear_req
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  // Handshake: a request transfers on a cycle with req_valid & req_ready, a
  // response on a cycle with rsp_valid & rsp_ready; requests must hold until taken.
`ifdef RAM8_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_RESP, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rsp_rdata;
  logic [WIDTH-1:0]  w_wdata;
  logic              w_accept;
  logic              w_clear;

`ifdef RAM8_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_idx;
  assign w_clear = clear_req;
`else
  assign w_clear = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    word_load    = '0;
    w_wdata      = req_wdata;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A clear command outranks a simultaneous request.
        req_ready = !w_clear;
`ifdef RAM8_CLEAR_EN
        if (w_clear) begin
          w_next_state = S_CLEAR;
        end else if (req_valid && !req_write) begin
          w_next_state = S_RESP;
        end
`else
        if (req_valid && !req_write) begin
          w_next_state = S_RESP;
        end
`endif
      end
      S_RESP: begin
        req_ready = rsp_ready;
        if (rsp_ready) begin
          w_next_state = (req_valid && !req_write) ? S_RESP : S_IDLE;
        end
      end
`ifdef RAM8_CLEAR_EN
      S_CLEAR: begin
        word_load[r_clr_idx] = 1'b1;
        w_wdata              = '0;
        if (r_clr_idx == {ADDR_W{1'b1}}) begin
          w_next_state = S_IDLE;
        end
      end
`endif
      default: w_next_state = S_IDLE;
    endcase
    w_accept = req_valid && req_ready;
    if (w_accept && req_write) begin
      word_load[req_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Storage deliberately ignores reset_n so a write on the reset edge still lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (word_load[i]) begin
        r_mem[i] <= w_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_rdata <= '0;
    end else if (w_accept && !req_write) begin
      r_rsp_rdata <= r_mem[req_addr];
    end
  end

`ifdef RAM8_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!reset_n || r_state != S_CLEAR) begin
      r_clr_idx <= '0;
    end else begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end
`endif

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram8_ctrl.sv
// Directed bench for ram8_ctrl: transaction-level model checked every cycle
// plus literal checks of the key test-plan values.
module tb_ram8_ctrl;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [WIDTH-1:0]  req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [WIDTH-1:0]  rsp_rdata;
  logic [DEPTH-1:0]  word_load;
  logic              busy;
  logic              clear_req = 1'b0;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ram8_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .word_load (word_load),
    .busy      (busy)
`ifdef RAM8_CLEAR_EN
    ,
    .clear_req (clear_req)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_known [DEPTH];
  bit               m_init = 0;
  bit               m_pend = 0;
  logic [WIDTH-1:0] m_rdata = '0;
  bit               m_rdata_known = 1;
  bit               m_clr = 0;
  int               m_clr_idx = 0;

  function automatic bit clear_in();
`ifdef RAM8_CLEAR_EN
    return clear_req;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ready();
    if (m_clr) return 1'b0;
    if (m_pend) return rsp_ready;
    return !clear_in();
  endfunction

  function automatic logic [DEPTH-1:0] exp_load();
    logic [DEPTH-1:0] v;
    v = '0;
    if (m_clr) v[m_clr_idx] = 1'b1;
    else if (req_valid && exp_ready() && req_write) v[req_addr] = 1'b1;
    return v;
  endfunction

  // One compare process: check at negedge, advance model at posedge.
  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("req_ready", 32'(req_ready), 32'(exp_ready()));
        check("word_load", 32'(word_load), 32'(exp_load()));
        check("busy", 32'(busy), 32'(m_pend || m_clr));
        check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
        if (m_pend && m_rdata_known) check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      end
      @(posedge clk);
      begin
        bit acc;
        acc = req_valid && exp_ready();
        if (m_clr) begin
          m_mem[m_clr_idx] = '0;
          m_known[m_clr_idx] = 1;
        end else if (acc && req_write) begin
          m_mem[req_addr] = req_wdata;
          m_known[req_addr] = 1;
        end
        if (!reset_n) begin
          m_init = 1;
          m_pend = 0;
          m_rdata = '0;
          m_rdata_known = 1;
          m_clr = 0;
          m_clr_idx = 0;
        end else if (m_clr) begin
          m_clr_idx++;
          if (m_clr_idx == DEPTH) begin
            m_clr = 0;
            m_clr_idx = 0;
          end
        end else if (!m_pend && clear_in()) begin
          m_clr = 1;
          m_clr_idx = 0;
        end else if (acc && !req_write) begin
          m_pend = 1;
          m_rdata = m_mem[req_addr];
          m_rdata_known = m_known[req_addr];
        end else if (acc || (m_pend && rsp_ready)) begin
          m_pend = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit wr, input int addr, input logic [WIDTH-1:0] data);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = ADDR_W'(addr);
    req_wdata = data;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic write_word(input int addr, input logic [WIDTH-1:0] data);
    drive_req(1'b1, addr, data);
    tick();
    idle_req();
  endtask

  // ---------------- directed stimulus ----------------
  logic [WIDTH-1:0] held;

  initial begin
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    // 1: write addr 3, read it back
    drive_req(1'b1, 3, 16'hBEEF);
    #1;
    check("t1 word_load", 32'(word_load), 32'h08);
    tick();
    drive_req(1'b0, 3, '0);
    tick();
    idle_req();
    #1;
    check("t1 rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1 rsp_rdata", 32'(rsp_rdata), 32'hBEEF);
    tick();

    // 2: preload then back-to-back reads
    for (int i = 0; i < DEPTH; i++) write_word(i, 16'(16'h1000 + i));
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(1'b0, i, '0);
      #1;
      check("t2 req_ready", 32'(req_ready), 32'd1);
      tick();
      check("t2 rsp_rdata", 32'(rsp_rdata), 32'h1000 + 32'(i));
    end
    idle_req();
    tick();

    // 3: backpressure on a read of addr 5
    rsp_ready = 1'b0;
    drive_req(1'b0, 5, '0);
    tick();
    drive_req(1'b0, 1, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3 rsp_valid", 32'(rsp_valid), 32'd1);
      check("t3 rsp_rdata", 32'(rsp_rdata), 32'h1005);
      check("t3 req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    idle_req();
    check("t3 second read", 32'(rsp_rdata), 32'h1001);
    tick();

    // 4: read-after-write on addr 2
    write_word(2, 16'h00FF);
    drive_req(1'b0, 2, '0);
    tick();
    idle_req();
    check("t4 raw", 32'(rsp_rdata), 32'h00FF);
    tick();

    // 5: reset while a response is pending
    rsp_ready = 1'b0;
    drive_req(1'b0, 6, '0);
    tick();
    idle_req();
    held = rsp_rdata;
    check("t5 pending", 32'(held), 32'h1006);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check("t5 rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5 rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("t5 busy", 32'(busy), 32'd0);
    rsp_ready = 1'b1;
    drive_req(1'b0, 6, '0);
    tick();
    idle_req();
    check("t5 retained", 32'(rsp_rdata), 32'h1006);
    tick();

`ifdef RAM8_CLEAR_EN
    // 6: clear walk beats a simultaneous write
    for (int i = 0; i < DEPTH; i++) write_word(i, 16'hFFFF);
    clear_req = 1'b1;
    drive_req(1'b1, 4, 16'h1234);
    #1;
    check("t6 req_ready", 32'(req_ready), 32'd0);
    check("t6 no load", 32'(word_load), 32'd0);
    tick();
    clear_req = 1'b0;
    idle_req();
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("t6 walk", 32'(word_load), 32'd1 << i);
      check("t6 busy", 32'(busy), 32'd1);
      tick();
    end
    check("t6 done busy", 32'(busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(1'b0, i, '0);
      tick();
      check("t6 cleared", 32'(rsp_rdata), 32'd0);
    end
    idle_req();
    tick();
`endif

    // mixed directed tail: write/read pairs with alternating backpressure
    for (int i = 0; i < DEPTH; i++) begin
      write_word(7 - i, 16'(16'hA500 ^ (i * 16'h0111)));
      rsp_ready = i[0];
      drive_req(1'b0, 7 - i, '0);
      tick();
      idle_req();
      rsp_ready = 1'b1;
      check("tail read", 32'(rsp_rdata), 32'(16'hA500 ^ (i * 16'h0111)));
      tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
